// File: rtl/aos_sr_read_sequencer_if.sv
// aos_sr_read_sequencer_if: SoftReg bundle between the host port, the read sequencer and the route tree
//   host_req         host -> sequencer request {valid, is_write, addr, data}
//   host_resp        sequencer -> host response {valid, data}
//   tree_req         sequencer -> request route tree
//   tree_resp        response route tree -> sequencer
//   clear_status     pulse that clears the sticky status outputs
//   overflow, timeout_app_mask, late_resp_count  sticky status from the sequencer
interface aos_sr_read_sequencer_if #(
    parameter int SR_NUM_APPS = 2
);
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } sr_req_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } sr_resp_t;
    sr_req_t                host_req;
    sr_resp_t               host_resp;
    sr_req_t                tree_req;
    sr_resp_t               tree_resp;
    logic                   clear_status;
    logic                   overflow;
    logic [SR_NUM_APPS-1:0] timeout_app_mask;
    logic [15:0]            late_resp_count;
    modport slave (
        input  host_req, tree_resp, clear_status,
        output host_resp, tree_req, overflow, timeout_app_mask, late_resp_count
    );
    modport master (
        output host_req, tree_resp, clear_status,
        input  host_resp, tree_req, overflow, timeout_app_mask, late_resp_count
    );
endinterface

// File: rtl/aos_sr_read_sequencer.sv
// aos_sr_read_sequencer: serialises host SoftReg reads (one outstanding), buffers requests, times out silent apps
//   clk  user clock
//   rst  asynchronous active-high reset
//   sr   slave side of aos_sr_read_sequencer_if: host_req/host_resp, tree_req/tree_resp,
//        clear_status and the sticky overflow / timeout_app_mask / late_resp_count status
module aos_sr_read_sequencer #(
    parameter int          SR_NUM_APPS    = 2,
    parameter int          FIFO_LOG_DEPTH = 3,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [63:0] TIMEOUT_DATA   = 64'hDEAD_DEAD_DEAD_DEAD
) (
    input logic                     clk,
    input logic                     rst,
    aos_sr_read_sequencer_if.slave  sr
);
    localparam int DEPTH = 1 << FIFO_LOG_DEPTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t                  r_state, w_next;
    logic [FIFO_LOG_DEPTH:0] r_wp, r_rp;
    logic                    r_mem_wr   [DEPTH];
    logic [31:0]             r_mem_addr [DEPTH];
    logic [63:0]             r_mem_data [DEPTH];
    logic [TW-1:0]           r_timer;
    logic [3:0]              r_app;
    logic                    r_tv, r_tw, r_rv, r_overflow;
    logic [31:0]             r_ta;
    logic [63:0]             r_td, r_rd;
    logic [SR_NUM_APPS-1:0]  r_mask;
    logic [15:0]             r_late;
    logic                    w_empty, w_full, w_push, w_head_wr, w_mapped;
    logic [31:0]             w_head_addr;
    logic [63:0]             w_head_data;
    logic [3:0]              w_head_app;
    logic                    w_pop, w_issue, w_resp_v, w_timeout, w_late;
    logic [63:0]             w_resp_d;
    logic [SR_NUM_APPS-1:0]  w_mask_set;
    // extra pointer bit distinguishes full from empty when the indices match
    assign w_empty     = r_wp == r_rp;
    assign w_full      = (r_wp[FIFO_LOG_DEPTH] != r_rp[FIFO_LOG_DEPTH]) &&
                         (r_wp[FIFO_LOG_DEPTH-1:0] == r_rp[FIFO_LOG_DEPTH-1:0]);
    assign w_push      = sr.host_req.valid && !w_full;
    assign w_head_wr   = r_mem_wr[r_rp[FIFO_LOG_DEPTH-1:0]];
    assign w_head_addr = r_mem_addr[r_rp[FIFO_LOG_DEPTH-1:0]];
    assign w_head_data = r_mem_data[r_rp[FIFO_LOG_DEPTH-1:0]];
    assign w_head_app  = w_head_addr[6:3];
    assign w_mapped    = {1'b0, w_head_app} < 5'(SR_NUM_APPS);
    assign w_mask_set  = w_timeout ? (SR_NUM_APPS'(1) << r_app) : '0;
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_issue   = 1'b0;
        w_resp_v  = 1'b0;
        w_resp_d  = '0;
        w_timeout = 1'b0;
        w_late    = 1'b0;
        if (r_state == S_IDLE) begin
            w_late = sr.tree_resp.valid;
            if (!w_empty) begin
                w_pop    = 1'b1;
                w_issue  = w_mapped;
                w_next   = (w_mapped && !w_head_wr) ? S_WAIT : S_IDLE;
                // unmapped reads are answered locally; unmapped writes vanish
                w_resp_v = !w_mapped && !w_head_wr;
                w_resp_d = w_resp_v ? TIMEOUT_DATA : '0;
            end
        end else if (sr.tree_resp.valid) begin
            // checked before the timer so a response on the last cycle still wins
            w_resp_v = 1'b1;
            w_resp_d = sr.tree_resp.data;
            w_next   = S_IDLE;
        end else if (r_timer == T_LAST) begin
            w_resp_v  = 1'b1;
            w_resp_d  = TIMEOUT_DATA;
            w_timeout = 1'b1;
            w_next    = S_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_wr[r_wp[FIFO_LOG_DEPTH-1:0]]   <= sr.host_req.is_write;
            r_mem_addr[r_wp[FIFO_LOG_DEPTH-1:0]] <= sr.host_req.addr;
            r_mem_data[r_wp[FIFO_LOG_DEPTH-1:0]] <= sr.host_req.data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_timer    <= '0;
            r_app      <= '0;
            r_tv       <= 1'b0;
            r_tw       <= 1'b0;
            r_ta       <= '0;
            r_td       <= '0;
            r_rv       <= 1'b0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
            r_mask     <= '0;
            r_late     <= '0;
        end else begin
            r_state    <= w_next;
            r_wp       <= w_push ? r_wp + 1'b1 : r_wp;
            r_rp       <= w_pop ? r_rp + 1'b1 : r_rp;
            r_timer    <= w_pop ? '0 : (r_state == S_WAIT) ? r_timer + 1'b1 : r_timer;
            r_app      <= w_pop ? w_head_app : r_app;
            r_tv       <= w_issue;
            r_tw       <= w_issue && w_head_wr;
            r_ta       <= w_issue ? w_head_addr : '0;
            r_td       <= w_issue ? w_head_data : '0;
            r_rv       <= w_resp_v;
            r_rd       <= w_resp_d;
            // a new event in the clearing cycle survives the clear
            r_overflow <= (sr.host_req.valid && w_full) || (r_overflow && !sr.clear_status);
            r_mask     <= (sr.clear_status ? '0 : r_mask) | w_mask_set;
            if (w_late)
                r_late <= sr.clear_status ? 16'd1 : (r_late == 16'hFFFF) ? r_late : r_late + 16'd1;
            else if (sr.clear_status)
                r_late <= '0;
        end
    end
    assign sr.tree_req         = {r_tv, r_tw, r_ta, r_td};
    assign sr.host_resp        = {r_rv, r_rd};
    assign sr.overflow         = r_overflow;
    assign sr.timeout_app_mask = r_mask;
    assign sr.late_resp_count  = r_late;
endmodule
